// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin time-sharing of one serial sequence detector among N_CH bit sources
module seq_detect_sched #(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         bit_in,
    output logic [N_CH-1:0]         gnt,
    output logic [N_CH-1:0]         bit_ready,
    output logic                    det_rst,
    output logic                    det_x,
    input  logic                    det_z,
    output logic                    done,
    output logic                    aborted,
    output logic [$clog2(N_CH)-1:0] done_ch,
    output logic [CNT_W-1:0]        hit_count
);
    localparam int CH_W = $clog2(N_CH);
    localparam int BC_W = $clog2(FRAME_LEN + 1);
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, REPORT} state_t;
    state_t          state, state_nx;
    logic [CH_W-1:0] ch, last_ch, pick, cand;
    logic [BC_W-1:0] bit_cnt;
    logic [CNT_W-1:0] acc, acc_nx;
    logic            consume, drop, last_bit;
    // scan downwards so the nearest requester after last_ch is written last
    always_comb begin
        pick = last_ch;
        cand = last_ch;
        for (int i = N_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last_ch) + i) % N_CH);
            if (req[cand]) pick = cand;
        end
    end
    always_comb begin
        consume      = state == STREAM && req[ch];
        drop         = state == STREAM && !req[ch];
        acc_nx       = (consume && det_z && acc != '1) ? acc + 1'b1 : acc;
        last_bit     = consume && bit_cnt == BC_W'(FRAME_LEN - 1);
        gnt          = '0;
        bit_ready    = '0;
        gnt[ch]      = state == CLEAR || state == STREAM;
        bit_ready[ch] = consume;
        det_rst      = rst || state == CLEAR;
        det_x        = state == STREAM && bit_in[ch];
        case (state)
            IDLE:    state_nx = |req ? CLEAR : IDLE;
            CLEAR:   state_nx = STREAM;
            STREAM:  state_nx = (drop || last_bit) ? REPORT : STREAM;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // report registers load on the STREAM->REPORT edge so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            ch        <= '0;
            last_ch   <= CH_W'(N_CH - 1);
            bit_cnt   <= '0;
            acc       <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            done_ch   <= '0;
            hit_count <= '0;
        end else begin
            if (state == IDLE) ch <= pick;
            if (state == CLEAR) begin
                bit_cnt <= '0;
                acc     <= '0;
            end
            if (consume) begin
                bit_cnt <= bit_cnt + 1'b1;
                acc     <= acc_nx;
            end
            done <= drop || last_bit;
            if (drop || last_bit) begin
                aborted   <= drop;
                done_ch   <= ch;
                hit_count <= acc_nx;
            end
            if (state == REPORT) last_ch <= ch;
        end
    end
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed bench with det_z = det_x, so hits equal the count of 1 bits
module tb_seq_detect_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] bit_in;
    logic [3:0] gnt, bit_ready, gnt_s, bit_ready_s;
    logic       det_rst, det_x, done, aborted, det_rst_s, det_x_s, done_s, aborted_s;
    logic [1:0] done_ch, done_ch_s;
    logic [4:0] hit_count;
    logic [2:0] hit_count_s;
    logic [15:0] pat [4];
    logic [3:0]  bidx [4];
    logic [3:0]  prev_gnt = 4'b0000;
    typedef struct packed {logic ab; logic [1:0] ch; logic [4:0] hc; logic [2:0] hs;} rec_t;
    rec_t done_q [$];
    int   gnt_q [$];
    int   n_cmp = 0, n_bad = 0, bad_oh = 0, bad_s = 0;
    int   n, k, t, nd;

    always #5 clk = ~clk;

    seq_detect_sched #(.N_CH(4), .FRAME_LEN(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt), .bit_ready(bit_ready),
        .det_rst(det_rst), .det_x(det_x), .det_z(det_x), .done(done), .aborted(aborted),
        .done_ch(done_ch), .hit_count(hit_count));

    seq_detect_sched #(.N_CH(4), .FRAME_LEN(16), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt_s), .bit_ready(bit_ready_s),
        .det_rst(det_rst_s), .det_x(det_x_s), .det_z(det_x_s), .done(done_s), .aborted(aborted_s),
        .done_ch(done_ch_s), .hit_count(hit_count_s));

    // each channel streams its pattern MSB first, restarting at every CLEAR
    always @(posedge clk)
        for (int c = 0; c < 4; c++)
            if (gnt[c] && !bit_ready[c]) bidx[c] <= 4'd0;
            else if (bit_ready[c])       bidx[c] <= bidx[c] + 4'd1;

    always_comb
        for (int c = 0; c < 4; c++) bit_in[c] = pat[c][4'd15 - bidx[c]];

    function automatic int oh_idx(input logic [3:0] g);
        oh_idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) oh_idx = i;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_q.push_back({aborted, done_ch, hit_count, hit_count_s});
            if (gnt != 4'b0 && prev_gnt == 4'b0) gnt_q.push_back(oh_idx(gnt));
            if (gnt != 4'b0 && !$onehot(gnt)) bad_oh++;
        end
        if ({gnt_s, bit_ready_s, det_rst_s, done_s, aborted_s, done_ch_s} !==
            {gnt, bit_ready, det_rst, done, aborted, done_ch}) bad_s++;
        prev_gnt = gnt;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_q.delete();
        gnt_q.delete();
    endtask

    task automatic wait_dones(input int cnt);
        int w = 0;
        while (done_q.size() < cnt && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("done_timeout", done_q.size() >= cnt, 1);
    endtask

    task automatic wait_bits(input int c, input int cnt);
        k = 0;
        t = 0;
        while (k < cnt && t < 100) begin
            @(negedge clk);
            if (bit_ready[c]) k++;
            t++;
        end
        chk("bits_timeout", k, cnt);
    endtask

    initial begin
        pat[0] = 16'hAAAA;
        pat[1] = 16'hD80F;
        pat[2] = 16'hFFFF;
        pat[3] = 16'h0001;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_done_ch", done_ch, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_det_x", det_x, 0);
        chk("rst_det_rst", det_rst, 1);

        rst = 1'b0;
        req = 4'b0001;
        n = 1;
        @(negedge clk); n++;
        chk("t1_clear_gnt", gnt, 4'b0001);
        chk("t1_clear_det_rst", det_rst, 1);
        chk("t1_clear_ready", bit_ready, 0);
        @(negedge clk); n++;
        chk("t1_stream_ready", bit_ready, 4'b0001);
        chk("t1_stream_det_rst", det_rst, 0);
        chk("t1_first_bit", det_x, 1);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", n, 19);
        chk("t1_done_ch", done_ch, 0);
        chk("t1_hit", hit_count, 8);
        chk("t1_aborted", aborted, 0);
        chk("t1_hit_sat", hit_count_s, 7);
        req = 4'b0000;

        do_reset();
        req = 4'b1111;
        wait_dones(5);
        req = 4'b0000;
        if (done_q.size() >= 5 && gnt_q.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("t2_order", gnt_q[i], i % 4);
                chk("t2_ch", done_q[i].ch, i % 4);
                chk("t2_ab", done_q[i].ab, 0);
                chk("t3_hit", done_q[i].hc, (i % 4 == 2) ? 16 : (i % 4 == 3) ? 1 : 8);
                chk("t3_hit_sat", done_q[i].hs, (i % 4 == 3) ? 1 : 7);
            end

        do_reset();
        req = 4'b0010;
        wait_bits(1, 5);
        @(negedge clk);
        req = 4'b1101;
        wait_dones(4);
        req = 4'b0000;
        if (done_q.size() >= 4 && gnt_q.size() >= 4) begin
            chk("t4_ch", done_q[0].ch, 1);
            chk("t4_aborted", done_q[0].ab, 1);
            chk("t4_hit", done_q[0].hc, 4);
            chk("t4_hit_s", done_q[0].hs, 4);
            chk("t4_next_ab", done_q[1].ab, 0);
            for (int i = 0; i < 4; i++) chk("t4_order", gnt_q[i], (i + 1) % 4);
        end

        do_reset();
        req = 4'b0100;
        wait_bits(2, 8);
        rst = 1'b1;
        nd = done_q.size();
        @(negedge clk);
        chk("t5_gnt", gnt, 0);
        chk("t5_det_rst", det_rst, 1);
        chk("t5_done", done, 0);
        chk("t5_ready", bit_ready, 0);
        req = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        gnt_q.delete();
        chk("t5_no_done", done_q.size(), nd);
        wait_dones(nd + 3);
        req = 4'b0000;
        if (done_q.size() >= nd + 3 && gnt_q.size() >= 3) begin
            chk("t5_first_ch", done_q[nd].ch, 0);
            chk("t5_first_hit", done_q[nd].hc, 8);
            chk("t6_second_ch", done_q[nd + 1].ch, 2);
            chk("t6_second_hit", done_q[nd + 1].hc, 16);
            chk("t6_third_ch", done_q[nd + 2].ch, 0);
            chk("t6_order0", gnt_q[0], 0);
            chk("t6_order1", gnt_q[1], 2);
            chk("t6_order2", gnt_q[2], 0);
        end
        repeat (3) @(negedge clk);
        chk("gnt_onehot", bad_oh, 0);
        chk("narrow_match", bad_s, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
